tile_loop_scheduler: RTL and testbench

TILE_LOOP_SCHEDULER -- requirements
Module: tile_loop_scheduler

---
 rtl/tile_loop_scheduler_pkg.sv | 25 ++
 rtl/tile_loop_scheduler_addr.sv | 113 +++++++++++
 rtl/tile_loop_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_tile_loop_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_loop_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tile_loop_scheduler_pkg
// Shared accelerator package: scheduler state encoding and the default element
// sizes (bytes per activation, weight and partial sum) used by the scheduler
// and its address generator.
// -----------------------------------------------------------------------------
package tile_loop_scheduler_pkg;

   localparam int unsigned BYTES_I_DEF = 1;
   localparam int unsigned BYTES_W_DEF = 1;
   localparam int unsigned BYTES_P_DEF = 4;

   typedef enum logic [3:0] {
      IDLE,
      LD_W,
      LD_I,
      LD_B,
      PASS,
      WAIT_P,
      ST_O,
      ADV,
      FIN
   } state_e;

endpackage

// File: rtl/tile_loop_scheduler_addr.sv
// -----------------------------------------------------------------------------
// tile_addr_gen
// Combinational generator for the clipped tile sizes and the DMA address,
// length and direction that belong to the current scheduler state.
// Ports:
//   state_i                  current scheduler state
//   cfg_*_i, tile_*_i        latched layer dimensions and tile sizes
//   k0_i, r0_i, d0_i, ch_i   loop origins and per-channel counter
//   base_*_i                 DRAM base addresses
//   k_real_o/d_real_o/r_real_o  tile sizes clipped to the layer edge
//   last_d_o                 current D tile is the last one
//   read_o, addr_o, len_o    DMA direction, byte address and byte length
// -----------------------------------------------------------------------------
module tile_addr_gen
   import tile_loop_scheduler_pkg::*;
#(
   parameter int DIM_W   = 10,
   parameter int ADDR_W  = 32,
   parameter int BYTES_I = BYTES_I_DEF,
   parameter int BYTES_W = BYTES_W_DEF,
   parameter int BYTES_P = BYTES_P_DEF
) (
   input  state_e            state_i,
   input  logic [DIM_W-1:0]  cfg_D_i,
   input  logic [DIM_W-1:0]  cfg_K_i,
   input  logic [DIM_W-1:0]  cfg_H_i,
   input  logic [DIM_W-1:0]  cfg_W_i,
   input  logic [DIM_W-1:0]  tile_D_i,
   input  logic [DIM_W-1:0]  tile_K_i,
   input  logic [DIM_W-1:0]  tile_R_i,
   input  logic [DIM_W-1:0]  k0_i,
   input  logic [DIM_W-1:0]  r0_i,
   input  logic [DIM_W-1:0]  d0_i,
   input  logic [DIM_W-1:0]  ch_i,
   input  logic [ADDR_W-1:0] base_ifmap_i,
   input  logic [ADDR_W-1:0] base_weight_i,
   input  logic [ADDR_W-1:0] base_bias_i,
   input  logic [ADDR_W-1:0] base_ofmap_i,
   output logic [DIM_W-1:0]  k_real_o,
   output logic [DIM_W-1:0]  d_real_o,
   output logic [DIM_W-1:0]  r_real_o,
   output logic              last_d_o,
   output logic              read_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [ADDR_W-1:0] len_o
);

   localparam logic [ADDR_W-1:0] BI_A = ADDR_W'(BYTES_I);
   localparam logic [ADDR_W-1:0] BW_A = ADDR_W'(BYTES_W);
   localparam logic [ADDR_W-1:0] BP_A = ADDR_W'(BYTES_P);

   function automatic logic [DIM_W-1:0] clip(input logic [DIM_W-1:0] t,
                                             input logic [DIM_W-1:0] rem);
      return (t < rem) ? t : rem;
   endfunction

   function automatic logic [ADDR_W-1:0] wide(input logic [DIM_W-1:0] v);
      return ADDR_W'(v);
   endfunction

   logic [DIM_W:0]    d_end;
   logic [ADDR_W-1:0] k0_a, r0_a, d0_a, ch_a, D_a, H_a, W_a, kr_a, dr_a, rr_a;

   assign k_real_o = clip(tile_K_i, cfg_K_i - k0_i);
   assign d_real_o = clip(tile_D_i, cfg_D_i - d0_i);
   assign r_real_o = clip(tile_R_i, cfg_H_i - r0_i);

   // One extra bit so d0 + d_real cannot wrap when D sits near 2^DIM_W.
   assign d_end    = {1'b0, d0_i} + {1'b0, d_real_o};
   assign last_d_o = (d_end >= {1'b0, cfg_D_i});

   assign k0_a = wide(k0_i);
   assign r0_a = wide(r0_i);
   assign d0_a = wide(d0_i);
   assign ch_a = wide(ch_i);
   assign D_a  = wide(cfg_D_i);
   assign H_a  = wide(cfg_H_i);
   assign W_a  = wide(cfg_W_i);
   assign kr_a = wide(k_real_o);
   assign dr_a = wide(d_real_o);
   assign rr_a = wide(r_real_o);

   // All products are taken at ADDR_W and wrap modulo 2^ADDR_W.
   always_comb begin
      read_o = 1'b0;
      addr_o = '0;
      len_o  = '0;
      case (state_i)
         LD_W: begin
            read_o = 1'b1;
            addr_o = base_weight_i + (k0_a * D_a + d0_a * kr_a) * BW_A;
            len_o  = kr_a * dr_a * BW_A;
         end
         LD_I: begin
            read_o = 1'b1;
            addr_o = base_ifmap_i + ((d0_a + ch_a) * H_a + r0_a) * W_a * BI_A;
            len_o  = rr_a * W_a * BI_A;
         end
         LD_B: begin
            read_o = 1'b1;
            addr_o = base_bias_i + k0_a * BP_A;
            len_o  = kr_a * BP_A;
         end
         ST_O: begin
            read_o = 1'b0;
            addr_o = base_ofmap_i + ((k0_a + ch_a) * H_a + r0_a) * W_a * BP_A;
            len_o  = rr_a * W_a * BP_A;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/tile_loop_scheduler.sv
// -----------------------------------------------------------------------------
// tile_loop_scheduler
// Walks a convolution layer tile by tile (k0 outer, r0 middle, d0 inner),
// loading weights, input rows and bias over a single-outstanding DMA port,
// launching one compute pass per tile and storing output rows after the last
// D tile of each (k0, r0) block.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   start_i / busy_o / done_o          layer control
//   cfg_*_i, tile_*_i, bias_en_i       layer shape, tile sizes, bias enable
//   base_*_i                           DRAM base addresses
//   dma_*                              DMA request / completion handshake
//   pass_*                             compute pass start / done and tile info
// -----------------------------------------------------------------------------
module tile_loop_scheduler
   import tile_loop_scheduler_pkg::*;
#(
   parameter int DIM_W   = 10,
   parameter int ADDR_W  = 32,
   parameter int BYTES_I = BYTES_I_DEF,
   parameter int BYTES_W = BYTES_W_DEF,
   parameter int BYTES_P = BYTES_P_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic [DIM_W-1:0]  cfg_D_i,
   input  logic [DIM_W-1:0]  cfg_K_i,
   input  logic [DIM_W-1:0]  cfg_H_i,
   input  logic [DIM_W-1:0]  cfg_W_i,
   input  logic [DIM_W-1:0]  tile_D_i,
   input  logic [DIM_W-1:0]  tile_K_i,
   input  logic [DIM_W-1:0]  tile_R_i,
   input  logic              bias_en_i,
   input  logic [ADDR_W-1:0] base_ifmap_i,
   input  logic [ADDR_W-1:0] base_weight_i,
   input  logic [ADDR_W-1:0] base_bias_i,
   input  logic [ADDR_W-1:0] base_ofmap_i,
   output logic              dma_valid_o,
   input  logic              dma_ready_i,
   output logic              dma_read_o,
   output logic [ADDR_W-1:0] dma_addr_o,
   output logic [ADDR_W-1:0] dma_len_o,
   input  logic              dma_done_i,
   output logic              pass_start_o,
   input  logic              pass_done_i,
   output logic [DIM_W-1:0]  pass_k_o,
   output logic [DIM_W-1:0]  pass_d_o,
   output logic [DIM_W-1:0]  pass_r_o,
   output logic              pass_first_d_o,
   output logic              pass_last_d_o
);

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  k0_q, k0_d, r0_q, r0_d, d0_q, d0_d, ch_q, ch_d;
   logic              wait_q, wait_d;
   logic [DIM_W-1:0]  D_q, K_q, H_q, W_q, tD_q, tK_q, tR_q;
   logic              bias_q;
   logic [ADDR_W-1:0] bi_q, bw_q, bb_q, bo_q;

   logic              latch_cfg, cfg_zero, in_dma, dma_vld, accept, xfer_done, in_pass;
   logic [DIM_W-1:0]  k_real, d_real, r_real;
   logic              last_d, gen_read;
   logic [ADDR_W-1:0] gen_addr, gen_len;
   logic [DIM_W:0]    d_nxt, r_nxt, k_nxt;

   tile_addr_gen #(
      .DIM_W(DIM_W), .ADDR_W(ADDR_W),
      .BYTES_I(BYTES_I), .BYTES_W(BYTES_W), .BYTES_P(BYTES_P)
   ) u_addr (
      .state_i(state_q),
      .cfg_D_i(D_q), .cfg_K_i(K_q), .cfg_H_i(H_q), .cfg_W_i(W_q),
      .tile_D_i(tD_q), .tile_K_i(tK_q), .tile_R_i(tR_q),
      .k0_i(k0_q), .r0_i(r0_q), .d0_i(d0_q), .ch_i(ch_q),
      .base_ifmap_i(bi_q), .base_weight_i(bw_q),
      .base_bias_i(bb_q), .base_ofmap_i(bo_q),
      .k_real_o(k_real), .d_real_o(d_real), .r_real_o(r_real),
      .last_d_o(last_d), .read_o(gen_read), .addr_o(gen_addr), .len_o(gen_len)
   );

   assign cfg_zero = (D_q == '0) || (K_q == '0) || (H_q == '0) || (W_q == '0) ||
                     (tD_q == '0) || (tK_q == '0) || (tR_q == '0);

   // A degenerate layer leaves LD_W for FIN without ever raising a request.
   assign in_dma    = ((state_q == LD_W) && !cfg_zero) || (state_q == LD_I) ||
                      (state_q == LD_B) || (state_q == ST_O);
   assign dma_vld   = in_dma && !wait_q;
   assign accept    = dma_vld && dma_ready_i;
   // dma_done_i only counts while a transfer is outstanding.
   assign xfer_done = in_dma && wait_q && dma_done_i;

   assign d_nxt = {1'b0, d0_q} + {1'b0, tD_q};
   assign r_nxt = {1'b0, r0_q} + {1'b0, tR_q};
   assign k_nxt = {1'b0, k0_q} + {1'b0, tK_q};

   always_comb begin
      state_d   = state_q;
      k0_d      = k0_q;
      r0_d      = r0_q;
      d0_d      = d0_q;
      ch_d      = ch_q;
      wait_d    = wait_q;
      latch_cfg = 1'b0;
      if (accept)    wait_d = 1'b1;
      if (xfer_done) wait_d = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            latch_cfg = 1'b1;
            k0_d      = '0;
            r0_d      = '0;
            d0_d      = '0;
            ch_d      = '0;
            wait_d    = 1'b0;
            state_d   = LD_W;
         end
         LD_W: begin
            if (cfg_zero) state_d = FIN;
            else if (xfer_done) begin
               ch_d    = '0;
               state_d = LD_I;
            end
         end
         LD_I: if (xfer_done) begin
            if (ch_q == d_real - DIM_W'(1)) begin
               ch_d    = '0;
               state_d = (bias_q && (d0_q == '0)) ? LD_B : PASS;
            end else begin
               ch_d = ch_q + DIM_W'(1);
            end
         end
         LD_B: if (xfer_done) state_d = PASS;
         PASS: state_d = WAIT_P;
         WAIT_P: if (pass_done_i) begin
            ch_d    = '0;
            state_d = last_d ? ST_O : ADV;
         end
         ST_O: if (xfer_done) begin
            if (ch_q == k_real - DIM_W'(1)) begin
               ch_d    = '0;
               state_d = ADV;
            end else begin
               ch_d = ch_q + DIM_W'(1);
            end
         end
         ADV: begin
            state_d = LD_W;
            if (d_nxt < {1'b0, D_q}) begin
               d0_d = d_nxt[DIM_W-1:0];
            end else begin
               d0_d = '0;
               if (r_nxt < {1'b0, H_q}) begin
                  r0_d = r_nxt[DIM_W-1:0];
               end else begin
                  r0_d = '0;
                  if (k_nxt < {1'b0, K_q}) k0_d = k_nxt[DIM_W-1:0];
                  else                     state_d = FIN;
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k0_q    <= '0;
         r0_q    <= '0;
         d0_q    <= '0;
         ch_q    <= '0;
         wait_q  <= 1'b0;
         D_q     <= '0;
         K_q     <= '0;
         H_q     <= '0;
         W_q     <= '0;
         tD_q    <= '0;
         tK_q    <= '0;
         tR_q    <= '0;
         bias_q  <= 1'b0;
         bi_q    <= '0;
         bw_q    <= '0;
         bb_q    <= '0;
         bo_q    <= '0;
      end else begin
         state_q <= state_d;
         k0_q    <= k0_d;
         r0_q    <= r0_d;
         d0_q    <= d0_d;
         ch_q    <= ch_d;
         wait_q  <= wait_d;
         if (latch_cfg) begin
            D_q    <= cfg_D_i;
            K_q    <= cfg_K_i;
            H_q    <= cfg_H_i;
            W_q    <= cfg_W_i;
            tD_q   <= tile_D_i;
            tK_q   <= tile_K_i;
            tR_q   <= tile_R_i;
            bias_q <= bias_en_i;
            bi_q   <= base_ifmap_i;
            bw_q   <= base_weight_i;
            bb_q   <= base_bias_i;
            bo_q   <= base_ofmap_i;
         end
      end
   end

   // Request and pass fields are forced to zero outside their active window so
   // the interface reads as quiet whenever nothing is being offered.
   assign in_pass        = (state_q == PASS) || (state_q == WAIT_P);
   assign busy_o         = (state_q != IDLE);
   assign done_o         = (state_q == FIN);
   assign dma_valid_o    = dma_vld;
   assign dma_read_o     = dma_vld && gen_read;
   assign dma_addr_o     = dma_vld ? gen_addr : '0;
   assign dma_len_o      = dma_vld ? gen_len  : '0;
   assign pass_start_o   = (state_q == PASS);
   assign pass_k_o       = in_pass ? k_real : '0;
   assign pass_d_o       = in_pass ? d_real : '0;
   assign pass_r_o       = in_pass ? r_real : '0;
   assign pass_first_d_o = in_pass && (d0_q == '0);
   assign pass_last_d_o  = in_pass && last_d;

endmodule

// File: tb/tb_tile_loop_scheduler.sv
module tb_tile_loop_scheduler;

   localparam int DIM_W  = 10;
   localparam int ADDR_W = 32;
   localparam logic [31:0] BI = 32'h2000_0000;
   localparam logic [31:0] BW = 32'h1000_0000;
   localparam logic [31:0] BB = 32'h3000_0000;
   localparam logic [31:0] BO = 32'h4000_0000;

   logic clk = 1'b0;
   logic rst_n;
   logic start_i;
   logic busy_o, done_o;
   logic [DIM_W-1:0] cfg_D, cfg_K, cfg_H, cfg_W, t_D, t_K, t_R;
   logic bias_en;
   logic dma_valid_o, dma_ready_i, dma_read_o, dma_done_i;
   logic [ADDR_W-1:0] dma_addr_o, dma_len_o;
   logic pass_start_o, pass_done_i, pass_first_d_o, pass_last_d_o;
   logic [DIM_W-1:0] pass_k_o, pass_d_o, pass_r_o;

   always #5 clk = ~clk;

   tile_loop_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .cfg_D_i(cfg_D), .cfg_K_i(cfg_K), .cfg_H_i(cfg_H), .cfg_W_i(cfg_W),
      .tile_D_i(t_D), .tile_K_i(t_K), .tile_R_i(t_R), .bias_en_i(bias_en),
      .base_ifmap_i(BI), .base_weight_i(BW), .base_bias_i(BB), .base_ofmap_i(BO),
      .dma_valid_o(dma_valid_o), .dma_ready_i(dma_ready_i), .dma_read_o(dma_read_o),
      .dma_addr_o(dma_addr_o), .dma_len_o(dma_len_o), .dma_done_i(dma_done_i),
      .pass_start_o(pass_start_o), .pass_done_i(pass_done_i),
      .pass_k_o(pass_k_o), .pass_d_o(pass_d_o), .pass_r_o(pass_r_o),
      .pass_first_d_o(pass_first_d_o), .pass_last_d_o(pass_last_d_o)
   );

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [31:0] len;
      int          npass;
   } dma_rec_t;

   typedef struct {
      logic [DIM_W-1:0] k, d, r;
      logic             first, last;
   } pass_rec_t;

   dma_rec_t  dq[$];
   pass_rec_t pq[$];
   dma_rec_t  drec;
   pass_rec_t prec;

   int n_cmp = 0, n_bad = 0;

   // DMA responder state
   int ready_dly = 0, done_dly = 2, hold_cnt = 0, done_cnt = 0, max_stall = 0;
   bit outstanding = 0, prev_stall = 0;
   int stab_viol = 0, ovl_viol = 0, valid_seen = 0;
   logic [31:0] prev_addr, prev_len;
   logic        prev_rd;

   // Pass responder state
   int pass_dly = 3, pcnt = 0, pstab_viol = 0, pstart_seen = 0, done_seen = 0;
   bit pass_pend = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      dma_ready_i = 1'b0;
      dma_done_i  = 1'b0;
      if (!rst_n) begin
         outstanding = 0;
         hold_cnt    = 0;
         prev_stall  = 0;
      end else begin
         if (dma_valid_o) valid_seen++;
         if (outstanding) begin
            if (dma_valid_o) ovl_viol++;
            if (done_cnt == 0) begin
               dma_done_i  = 1'b1;
               outstanding = 0;
            end else done_cnt--;
         end else if (dma_valid_o) begin
            if (prev_stall && (dma_addr_o !== prev_addr || dma_len_o !== prev_len ||
                               dma_read_o !== prev_rd)) stab_viol++;
            if (hold_cnt >= ready_dly) begin
               dma_ready_i = 1'b1;
               drec.rd = dma_read_o; drec.addr = dma_addr_o;
               drec.len = dma_len_o; drec.npass = pq.size();
               dq.push_back(drec);
               outstanding = 1;
               done_cnt    = done_dly;
               if (hold_cnt > max_stall) max_stall = hold_cnt;
               hold_cnt   = 0;
               prev_stall = 0;
            end else begin
               hold_cnt++;
               prev_stall = 1;
               prev_addr  = dma_addr_o;
               prev_len   = dma_len_o;
               prev_rd    = dma_read_o;
            end
         end else begin
            if (prev_stall) stab_viol++;
            prev_stall = 0;
         end
      end
   end

   always @(negedge clk) begin
      pass_done_i = 1'b0;
      if (done_o) done_seen++;
      if (!rst_n) pass_pend = 0;
      else if (pass_start_o) begin
         pstart_seen++;
         prec.k = pass_k_o; prec.d = pass_d_o; prec.r = pass_r_o;
         prec.first = pass_first_d_o; prec.last = pass_last_d_o;
         pq.push_back(prec);
         pass_pend = 1;
         pcnt = pass_dly;
      end else if (pass_pend) begin
         if (pass_k_o !== pq[$].k || pass_d_o !== pq[$].d || pass_r_o !== pq[$].r ||
             pass_first_d_o !== pq[$].first || pass_last_d_o !== pq[$].last) pstab_viol++;
         if (pcnt == 0) begin
            pass_done_i = 1'b1;
            pass_pend   = 0;
         end else pcnt--;
      end
   end

   task automatic start_layer(input int D, input int K, input int H, input int W,
                              input int tD, input int tK, input int tR, input bit b);
      dq.delete();
      pq.delete();
      @(negedge clk);
      cfg_D = DIM_W'(D); cfg_K = DIM_W'(K); cfg_H = DIM_W'(H); cfg_W = DIM_W'(W);
      t_D = DIM_W'(tD); t_K = DIM_W'(tK); t_R = DIM_W'(tR); bias_en = b;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit got = 0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         #1;
         if (done_o) got = 1;
      end
      chk(tag, got, 1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ctl"}, {busy_o, done_o, dma_valid_o, dma_read_o, pass_start_o,
                          pass_first_d_o, pass_last_d_o}, 0);
      chk({tag, "_addr"}, dma_addr_o, 0);
      chk({tag, "_len"}, dma_len_o, 0);
      chk({tag, "_pass"}, {pass_k_o, pass_d_o, pass_r_o}, 0);
   endtask

   initial begin
      int nb, nw, vs, ps, ds;
      bit got;
      rst_n = 1'b0; start_i = 1'b0;
      cfg_D = '0; cfg_K = '0; cfg_H = '0; cfg_W = '0;
      t_D = '0; t_K = '0; t_R = '0; bias_en = 1'b0;
      dma_ready_i = 1'b0; dma_done_i = 1'b0; pass_done_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_quiet("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Two D tiles, bias once, 32 output rows stored after the second pass.
      start_layer(64, 32, 4, 8, 32, 32, 4, 1);
      wait_done("t1_done", 5000);
      chk("t1_npass", pq.size(), 2);
      chk("t1_ndma", dq.size(), 99);
      chk("t1_w0", {dq[0].rd, dq[0].addr, dq[0].len}, {1'b1, BW, 32'd1024});
      chk("t1_i5", {dq[6].rd, dq[6].addr, dq[6].len}, {1'b1, BI + 32'd160, 32'd32});
      chk("t1_bias", {dq[33].rd, dq[33].addr, dq[33].len}, {1'b1, BB, 32'd128});
      chk("t1_w1", {dq[34].addr, dq[34].len}, {BW + 32'd1024, 32'd1024});
      nb = 0; nw = 0;
      foreach (dq[i]) begin
         if (dq[i].rd && dq[i].addr == BB) nb++;
         if (!dq[i].rd && dq[i].len == 32'd128 && dq[i].npass == 2) nw++;
      end
      chk("t1_bias_cnt", nb, 1);
      chk("t1_wr_cnt", nw, 32);
      chk("t1_wr_last", {dq[98].rd, dq[98].addr}, {1'b0, BO + 32'd3968});
      chk("t1_p0", {pq[0].k, pq[0].d, pq[0].r, pq[0].first, pq[0].last},
          {10'd32, 10'd32, 10'd4, 1'b1, 1'b0});
      chk("t1_p1", {pq[1].k, pq[1].d, pq[1].r, pq[1].first, pq[1].last},
          {10'd32, 10'd32, 10'd4, 1'b0, 1'b1});

      // Partial last D tile.
      start_layer(40, 32, 1, 4, 32, 32, 1, 0);
      wait_done("t2_done", 5000);
      chk("t2_npass", pq.size(), 2);
      chk("t2_d0", pq[0].d, 32);
      chk("t2_d1", {pq[1].d, pq[1].last}, {10'd8, 1'b1});
      chk("t2_ndma", dq.size(), 74);
      chk("t2_w1", {dq[33].addr, dq[33].len}, {BW + 32'd1024, 32'd256});
      chk("t2_i1", {dq[34].addr, dq[34].len}, {BI + 32'd128, 32'd4});

      // Partial last row tile.
      start_layer(1, 1, 5, 8, 1, 1, 2, 0);
      wait_done("t3_done", 2000);
      chk("t3_r", {pq[0].r, pq[1].r, pq[2].r}, {10'd2, 10'd2, 10'd1});
      chk("t3_i1", {dq[4].addr, dq[4].len}, {BI + 32'd16, 32'd16});
      chk("t3_ilast", {dq[7].rd, dq[7].addr, dq[7].len}, {1'b1, BI + 32'd32, 32'd8});
      chk("t3_olast", {dq[8].rd, dq[8].addr, dq[8].len}, {1'b0, BO + 32'd128, 32'd32});
      chk("t3_flags", {pq[2].first, pq[2].last}, 2'b11);

      // Back-pressure: ready held low for 7 cycles on every request.
      stab_viol = 0; ovl_viol = 0; max_stall = 0; ready_dly = 7;
      start_layer(1, 1, 1, 8, 1, 1, 1, 1);
      wait_done("t4_done", 2000);
      ready_dly = 0;
      chk("t4_stable", stab_viol, 0);
      chk("t4_overlap", ovl_viol, 0);
      chk("t4_stall", max_stall, 7);
      chk("t4_ndma", dq.size(), 4);
      chk("t4_pstable", pstab_viol, 0);

      // Degenerate layer: done two cycles after start, nothing issued.
      vs = valid_seen; ps = pstart_seen;
      start_layer(8, 0, 4, 8, 4, 4, 4, 1);
      #1;
      chk("t5_cyc1", {busy_o, done_o}, 2'b10);
      @(negedge clk);
      #1;
      chk("t5_cyc2", {busy_o, done_o}, 2'b11);
      @(negedge clk);
      #1;
      chk("t5_idle", {busy_o, done_o}, 2'b00);
      chk("t5_nodma", valid_seen - vs, 0);
      chk("t5_nopass", pstart_seen - ps, 0);

      // Reset while waiting for a pass, then a clean restart.
      pass_dly = 20;
      start_layer(1, 1, 1, 8, 1, 1, 1, 1);
      got = 0;
      for (int n = 0; n < 500 && !got; n++) begin
         @(negedge clk);
         if (pq.size() >= 1) got = 1;
      end
      chk("t6_pass_seen", got, 1);
      repeat (3) @(negedge clk);
      ds = done_seen;
      rst_n = 1'b0;
      #1;
      chk_quiet("t6_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pass_dly = 3;
      repeat (5) @(negedge clk);
      #1;
      chk("t6_no_done", {busy_o, 32'(done_seen - ds)}, 0);
      start_layer(1, 1, 1, 8, 1, 1, 1, 1);
      wait_done("t6_done", 2000);
      chk("t6_npass", pq.size(), 1);
      chk("t6_ndma", dq.size(), 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
